vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 30 +++
 rtl/vram_arbiter.sv | 97 +++++++++
 tb/tb_vram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Frame-buffer arbiter port bundle: VGA read request, game pixel writes, clear control, BRAM port.
// master = request/VGA side, slave = arbiter.
interface vram_arbiter_if #(
    parameter int DW = 12
);
    logic [16:0]   vga_addr;
    logic          vga_active;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_x;
    logic [6:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic [16:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;

    modport master (
        output vga_addr, vga_active, wr_valid, wr_x, wr_y, wr_data, clr_start, clr_color,
        input  wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_din
    );

    modport slave (
        input  vga_addr, vga_active, wr_valid, wr_x, wr_y, wr_data, clr_start, clr_color,
        output wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port frame BRAM arbiter: VGA reads first, then a full-buffer clear, then game pixel writes.
// Latency: grant decided in cycle N drives the registered memory port in cycle N+1.
// Backpressure: wr_ready drops while VGA is active, on clr_start, and for the whole clear.
module vram_arbiter #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int DW         = 12
) (
    input  logic         clk,
    input  logic         rst,
    vram_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int          PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [14:0] LAST   = 15'(PIXELS - 1);

    state_t        state_q, state_d;
    logic [14:0]   cnt_q, cnt_d;
    logic [DW-1:0] color_q, color_d;
    logic [16:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] din_q, din_d;
    logic          done_q, done_d;

    logic [14:0]   wr_lin;
    logic          wr_in_range;
    logic          wr_ready_int;

    assign wr_lin       = 15'(bus.wr_y) * 15'(IMG_WIDTH) + 15'(bus.wr_x);
    assign wr_in_range  = (int'(bus.wr_x) < IMG_WIDTH) && (int'(bus.wr_y) < IMG_HEIGHT);
    assign wr_ready_int = (state_q == IDLE) && !bus.vga_active && !bus.clr_start;

    assign bus.wr_ready = wr_ready_int;
    assign bus.clr_busy = (state_q == CLEAR);
    assign bus.clr_done = done_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_din  = din_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        addr_d  = bus.vga_addr;
        we_d    = 1'b0;
        din_d   = din_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else if (bus.wr_valid && wr_ready_int && wr_in_range) begin
                    // Out-of-range writes still handshake but leave the port on the VGA read.
                    addr_d = {2'b00, wr_lin};
                    we_d   = 1'b1;
                    din_d  = bus.wr_data;
                end
            end
            CLEAR: begin
                if (!bus.vga_active) begin
                    addr_d = {2'b00, cnt_q};
                    we_d   = 1'b1;
                    din_d  = color_q;
                    cnt_d  = cnt_q + 15'd1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic against a pixel-level model.
module tb_vram_arbiter;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int DW = 12;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    vram_arbiter_if #(.DW(DW)) bus ();

    vram_arbiter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vga_addr   = '0;
        bus.vga_active = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_data    = '0;
        bus.clr_start  = 1'b0;
        bus.clr_color  = '0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        idle_inputs();
        bus.vga_addr = 17'd77;
        rst = 1'b0;
        tick();
        tick();
        outs = {bus.mem_addr, bus.mem_we, bus.mem_din, bus.clr_busy, bus.clr_done};
        total++;
        if (outs !== 32'd0) $display("FAIL reset_outputs: got %h want 0", outs);
        else passed++;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we} !== {17'd77, 1'b0})
            $display("FAIL reset_idle_read: got addr %0d we %b want addr 77 we 0", bus.mem_addr, bus.mem_we);
        else passed++;
    endtask

    task automatic test_write_basic();
        idle_inputs();
        bus.wr_valid = 1'b1; bus.wr_x = 8'd5; bus.wr_y = 7'd2; bus.wr_data = 12'hF00;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL write_basic_ready: got %b want 1", bus.wr_ready);
        else passed++;
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {17'd325, 1'b1, 12'hF00})
            $display("FAIL write_basic_port: got addr %0d we %b din %h want 325 1 f00",
                     bus.mem_addr, bus.mem_we, bus.mem_din);
        else passed++;
        bus.wr_valid = 1'b0; bus.vga_addr = 17'd9;
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we} !== {17'd9, 1'b0})
            $display("FAIL write_basic_release: got addr %0d we %b want 9 0", bus.mem_addr, bus.mem_we);
        else passed++;
    endtask

    task automatic test_vga_priority();
        idle_inputs();
        bus.vga_active = 1'b1; bus.vga_addr = 17'd1000;
        bus.wr_valid = 1'b1; bus.wr_x = 8'd3; bus.wr_y = 7'd4; bus.wr_data = 12'h123;
        #1;
        total++;
        if (bus.wr_ready !== 1'b0) $display("FAIL vga_prio_ready: got %b want 0", bus.wr_ready);
        else passed++;
        tick();
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we} !== {17'd1000, 1'b0})
            $display("FAIL vga_prio_read: got addr %0d we %b want 1000 0", bus.mem_addr, bus.mem_we);
        else passed++;
        bus.vga_active = 1'b0;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL vga_prio_release_ready: got %b want 1", bus.wr_ready);
        else passed++;
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {17'd643, 1'b1, 12'h123})
            $display("FAIL vga_prio_write: got addr %0d we %b din %h want 643 1 123",
                     bus.mem_addr, bus.mem_we, bus.mem_din);
        else passed++;
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [7:0]  xs [3];
        logic [6:0]  ys [3];
        logic        we_exp [3];
        logic [16:0] a_exp [3];
        xs = '{8'd160, 8'd0, 8'd159};
        ys = '{7'd0, 7'd120, 7'd119};
        we_exp = '{1'b0, 1'b0, 1'b1};
        a_exp  = '{17'd55, 17'd55, 17'd19199};
        idle_inputs();
        bus.vga_addr = 17'd55;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1; bus.wr_x = xs[i]; bus.wr_y = ys[i]; bus.wr_data = 12'h0F0;
            #1;
            total++;
            if (bus.wr_ready !== 1'b1) $display("FAIL range_ready_%0d: got %b want 1", i, bus.wr_ready);
            else passed++;
            tick();
            total++;
            if ({bus.mem_addr, bus.mem_we} !== {a_exp[i], we_exp[i]})
                $display("FAIL range_port_%0d: got addr %0d we %b want %0d %b",
                         i, bus.mem_addr, bus.mem_we, a_exp[i], we_exp[i]);
            else passed++;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic        va, wv;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] d;
        logic [16:0] va_addr, exp_addr;
        logic        exp_we;
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            va = ($urandom_range(0, 9) < 3);
            wv = $urandom_range(0, 1) == 1;
            x  = 8'($urandom_range(0, 179));
            y  = 7'($urandom_range(0, 127));
            d  = 12'($urandom);
            va_addr = 17'($urandom_range(0, N - 1));
            bus.vga_active = va; bus.vga_addr = va_addr;
            bus.wr_valid = wv; bus.wr_x = x; bus.wr_y = y; bus.wr_data = d;
            #1;
            total++;
            if (bus.wr_ready !== !va) $display("FAIL rand_ready_%0d: got %b want %b", n, bus.wr_ready, !va);
            else passed++;
            if (wv && !va && int'(x) < W && int'(y) < H) begin
                exp_addr = 17'(int'(y) * W + int'(x));
                exp_we = 1'b1;
            end else begin
                exp_addr = va_addr;
                exp_we = 1'b0;
            end
            tick();
            total++;
            if ({bus.mem_addr, bus.mem_we} !== {exp_addr, exp_we} || (exp_we && bus.mem_din !== d))
                $display("FAIL rand_port_%0d: got addr %0d we %b din %h want %0d %b %h",
                         n, bus.mem_addr, bus.mem_we, bus.mem_din, exp_addr, exp_we, d);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_clear_full();
        int busy_cnt = 0, done_cnt = 0, errs = 0;
        logic last_done = 1'b0;
        idle_inputs();
        bus.clr_start = 1'b1; bus.clr_color = 12'h0A0;
        tick();
        bus.clr_start = 1'b0;
        total++;
        if ({bus.mem_we, bus.clr_busy} !== 2'b01)
            $display("FAIL clear_enter: got we %b busy %b want 0 1", bus.mem_we, bus.clr_busy);
        else passed++;
        for (int i = 0; i < N; i++) begin
            busy_cnt += int'(bus.clr_busy);
            tick();
            if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {17'(i), 1'b1, 12'h0A0}) errs++;
            done_cnt += int'(bus.clr_done);
            if (i == N - 1) last_done = bus.clr_done;
        end
        total++;
        if (errs != 0) $display("FAIL clear_writes: got %0d bad cycles want 0", errs);
        else passed++;
        total++;
        if (busy_cnt != N) $display("FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, N);
        else passed++;
        total++;
        if ({last_done, bus.clr_busy} !== 2'b10)
            $display("FAIL clear_done_pulse: got done %b busy %b want 1 0", last_done, bus.clr_busy);
        else passed++;
        tick();
        done_cnt += int'(bus.clr_done);
        total++;
        if (done_cnt != 1) $display("FAIL clear_done_count: got %0d want 1", done_cnt);
        else passed++;
    endtask

    task automatic test_clear_contention();
        int exp = 0, cycles = 0, errs = 0, ready_errs = 0;
        logic va;
        logic [16:0] va_addr;
        idle_inputs();
        bus.wr_valid = 1'b1; bus.wr_x = 8'd7; bus.wr_y = 7'd3; bus.wr_data = 12'hABC;
        bus.clr_start = 1'b1; bus.clr_color = 12'h5A5;
        #1;
        total++;
        if (bus.wr_ready !== 1'b0) $display("FAIL contend_start_ready: got %b want 0", bus.wr_ready);
        else passed++;
        tick();
        total++;
        if (bus.mem_we !== 1'b0) $display("FAIL contend_start_we: got %b want 0", bus.mem_we);
        else passed++;
        while (exp < N && cycles < 60000) begin
            va = $urandom_range(0, 1) == 1;
            va_addr = 17'($urandom_range(0, N - 1));
            bus.vga_active = va; bus.vga_addr = va_addr;
            bus.clr_start = ($urandom_range(0, 15) == 0);
            bus.clr_color = 12'hFFF;
            #1;
            if (bus.wr_ready !== 1'b0) ready_errs++;
            tick();
            cycles++;
            if (va) begin
                if ({bus.mem_addr, bus.mem_we} !== {va_addr, 1'b0}) errs++;
            end else begin
                if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {17'(exp), 1'b1, 12'h5A5}) errs++;
                exp++;
            end
            if (bus.clr_done === 1'b1 && exp != N) errs++;
        end
        bus.clr_start = 1'b0; bus.vga_active = 1'b0;
        total++;
        if (exp != N) $display("FAIL contend_timeout: got %0d writes want %0d", exp, N);
        else passed++;
        total++;
        if (errs != 0) $display("FAIL contend_port: got %0d bad cycles want 0", errs);
        else passed++;
        total++;
        if (ready_errs != 0) $display("FAIL contend_ready: got %0d ready cycles want 0", ready_errs);
        else passed++;
        total++;
        if (bus.clr_done !== 1'b1) $display("FAIL contend_done: got %b want 1", bus.clr_done);
        else passed++;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL contend_after_ready: got %b want 1", bus.wr_ready);
        else passed++;
        tick();
        total++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {17'd487, 1'b1, 12'hABC})
            $display("FAIL contend_after_write: got addr %0d we %b din %h want 487 1 abc",
                     bus.mem_addr, bus.mem_we, bus.mem_din);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_during_clear();
        logic [31:0] outs;
        int bad = 0;
        idle_inputs();
        bus.clr_start = 1'b1; bus.clr_color = 12'h0F0;
        tick();
        bus.clr_start = 1'b0;
        repeat (500) tick();
        total++;
        if ({bus.mem_addr, bus.mem_we} !== {17'd499, 1'b1})
            $display("FAIL rstclr_progress: got addr %0d we %b want 499 1", bus.mem_addr, bus.mem_we);
        else passed++;
        rst = 1'b0;
        tick();
        outs = {bus.mem_addr, bus.mem_we, bus.mem_din, bus.clr_busy, bus.clr_done};
        total++;
        if (outs !== 32'd0) $display("FAIL rstclr_outputs: got %h want 0", outs);
        else passed++;
        total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL rstclr_idle: got %b want 1", bus.wr_ready);
        else passed++;
        rst = 1'b1;
        repeat (4) begin
            tick();
            if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0 || bus.mem_we !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL rstclr_no_done: got %0d bad cycles want 0", bad);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_basic();
        test_vga_priority();
        test_out_of_range();
        test_random_traffic();
        test_clear_full();
        test_clear_contention();
        test_reset_during_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
